// File: rtl/vga_timing_pkg.sv
// Shared constants, swap FSM state type and sizing helpers for the VGA raster timing generator.
// Defaults describe the 640x480 @ 60 Hz mode driven from a 50 MHz system clock.
package vga_timing_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam int unsigned VGA_CLK_DIV  = 2;
    localparam bit          VGA_HS_POL   = 1'b0;
    localparam bit          VGA_VS_POL   = 1'b0;
    localparam int unsigned VGA_FRAME_W  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } swap_state_e;

    function automatic int unsigned vga_total(input int unsigned active,
                                              input int unsigned fp,
                                              input int unsigned sync_w,
                                              input int unsigned bp);
        return active + fp + sync_w + bp;
    endfunction

    // Counter width able to hold 0..total-1, never narrower than one bit.
    function automatic int unsigned vga_width(input int unsigned total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/pixel_clk_div.sv
// Divides the system clock into a one-cycle pixel strobe and a roughly square pixel clock.
// tick_o is the combinational early view of pix_en_o so the raster counters step on the same edge.
module pixel_clk_div
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV = VGA_CLK_DIV
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o,
    output logic pix_en_o,
    output logic pixel_clk_o
);

    localparam int unsigned   DW       = vga_width(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          pix_en_q;
    logic          pixel_clk_q;

    assign tick_o    = (div_cnt_q == DIV_LAST);
    assign div_cnt_d = tick_o ? '0 : div_cnt_q + 1'b1;

    // pixel_clk is low for the first half of each period, a period starting on the pix_en cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt_q   <= '0;
            pix_en_q    <= 1'b0;
            pixel_clk_q <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            pix_en_q    <= tick_o;
            pixel_clk_q <= (div_cnt_d >= DIV_HALF);
        end
    end

    assign pix_en_o    = pix_en_q;
    assign pixel_clk_o = pixel_clk_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with frame counter and vsync-aligned buffer swap.
// Sync/blank decodes are registered from next-state counters so they line up with DrawX/DrawY.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
    parameter bit          HS_POL   = VGA_HS_POL,
    parameter bit          VS_POL   = VGA_VS_POL,
    parameter int unsigned FRAME_W  = VGA_FRAME_W,
    localparam int unsigned H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int unsigned V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int unsigned XW      = vga_width(H_TOTAL),
    localparam int unsigned YW      = vga_width(V_TOTAL)
) (
    input  logic               Clk,
    input  logic               Reset,
    output logic               pix_en,
    output logic               pixel_clk,
    output logic               hs,
    output logic               vs,
    output logic               blank,
    output logic               sync,
    output logic [XW-1:0]      DrawX,
    output logic [YW-1:0]      DrawY,
    output logic               line_start,
    output logic               frame_start,
    input  logic               swap_req,
    output logic               swap_ack,
    output logic               waitFrame,
    output logic               buffer_sel,
    output logic [FRAME_W-1:0] frame_count
);

    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] HA_LAST  = XW'(H_ACTIVE - 1);
    localparam logic [XW-1:0] HS_FIRST = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_LAST  = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] VA_LAST  = YW'(V_ACTIVE - 1);
    localparam logic [YW-1:0] VS_FIRST = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_LAST  = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic tick;

    pixel_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_clk_div (
        .clk_i       (Clk),
        .rst_i       (Reset),
        .tick_o      (tick),
        .pix_en_o    (pix_en),
        .pixel_clk_o (pixel_clk)
    );

    logic [XW-1:0]      hc_q, hc_d;
    logic [YW-1:0]      vc_q, vc_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic               blank_q, blank_d;
    logic               line_start_q;
    logic               frame_start_q;
    logic [FRAME_W-1:0] frame_count_q;
    logic               h_wrap, v_wrap, boundary;

    assign h_wrap   = tick && (hc_q == H_LAST);
    assign v_wrap   = (vc_q == V_LAST);
    assign boundary = h_wrap && v_wrap;

    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (tick) begin
            hc_d = h_wrap ? '0 : hc_q + 1'b1;
            if (h_wrap) begin
                vc_d = v_wrap ? '0 : vc_q + 1'b1;
            end
        end
        hs_d    = ((hc_d >= HS_FIRST) && (hc_d <= HS_LAST)) ? HS_POL : ~HS_POL;
        vs_d    = ((vc_d >= VS_FIRST) && (vc_d <= VS_LAST)) ? VS_POL : ~VS_POL;
        blank_d = (hc_d <= HA_LAST) && (vc_d <= VA_LAST);
    end

    // Line/frame pulses last exactly the pix_en cycle; everything else holds between pixels
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hc_q          <= '0;
            vc_q          <= '0;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            blank_q       <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            line_start_q  <= h_wrap;
            frame_start_q <= boundary;
            if (tick) begin
                hc_q    <= hc_d;
                vc_q    <= vc_d;
                hs_q    <= hs_d;
                vs_q    <= vs_d;
                blank_q <= blank_d;
            end
            if (boundary) begin
                frame_count_q <= frame_count_q + 1'b1;
            end
        end
    end

    swap_state_e state_q, state_d;
    logic        swap_ack_q, swap_ack_d;
    logic        buffer_sel_q, buffer_sel_d;

    // The requester still holds swap_req during the ack cycle, so that cycle never opens a new request
    always_comb begin
        state_d      = state_q;
        swap_ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (swap_req && !swap_ack_q) begin
                    if (boundary) begin
                        swap_ack_d = 1'b1;
                    end else begin
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                if (boundary) begin
                    state_d    = IDLE;
                    swap_ack_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        buffer_sel_d = buffer_sel_q ^ swap_ack_d;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            swap_ack_q   <= 1'b0;
            buffer_sel_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            swap_ack_q   <= swap_ack_d;
            buffer_sel_q <= buffer_sel_d;
        end
    end

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank       = blank_q;
    assign sync        = 1'b0;
    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;
    assign swap_ack    = swap_ack_q;
    assign waitFrame   = (state_q == PEND);
    assign buffer_sel  = buffer_sel_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a tiny 8x6 raster: directed vector table, swap sequences and random run.
// The reference model derives every output from the cycle count since reset and a pending-swap flag.
module tb_vga_timing_gen;

    localparam int HA = 4, HFP = 1, HSY = 2, HBP = 1;
    localparam int VA = 3, VFP = 1, VSY = 1, VBP = 1;
    localparam int CD = 2;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam bit HSP = 1'b0, VSP = 1'b0;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        swap_req = 1'b0;
    logic        pix_en, pixel_clk, hs, vs, blank, sync;
    logic [2:0]  DrawX, DrawY;
    logic        line_start, frame_start, swap_ack, waitFrame, buffer_sel;
    logic [15:0] frame_count;

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
        .CLK_DIV  (CD), .HS_POL (HSP), .VS_POL (VSP), .FRAME_W (16)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .pix_en      (pix_en),
        .pixel_clk   (pixel_clk),
        .hs          (hs),
        .vs          (vs),
        .blank       (blank),
        .sync        (sync),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .line_start  (line_start),
        .frame_start (frame_start),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .waitFrame   (waitFrame),
        .buffer_sel  (buffer_sel),
        .frame_count (frame_count)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int t = 0;
    logic m_pend = 1'b0, m_buf = 1'b0, m_ack = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d: got %h expected %h", name, t, act, exp);
        end
    endtask

    // One Clk: drive inputs, take the edge, advance the model, compare every output.
    task automatic step(input logic req, input logic rst);
        logic pe, bnd, grant, ack_n, e_hs, e_vs, e_bl, e_pclk, e_ls, e_fs;
        int p, x, y, fc;
        swap_req = req;
        Reset    = rst;
        @(posedge Clk);
        #1;
        if (rst) begin
            t = 0; m_pend = 1'b0; m_buf = 1'b0; m_ack = 1'b0;
        end else begin
            t++;
            pe    = (t % CD) == 0;
            p     = (t / CD) % (HT * VT);
            bnd   = pe && (p == 0);
            grant = req && !m_ack;
            ack_n = 1'b0;
            if (bnd && (m_pend || grant)) begin
                ack_n = 1'b1; m_pend = 1'b0; m_buf = ~m_buf;
            end else if (grant) begin
                m_pend = 1'b1;
            end
            m_ack = ack_n;
        end
        pe     = (t > 0) && ((t % CD) == 0);
        p      = (t / CD) % (HT * VT);
        x      = p % HT;
        y      = p / HT;
        fc     = ((t / CD) / (HT * VT)) % 65536;
        e_pclk = (t % CD) >= (CD / 2);
        e_hs   = (x >= HA + HFP && x <= HA + HFP + HSY - 1) ? HSP : ~HSP;
        e_vs   = (y >= VA + VFP && y <= VA + VFP + VSY - 1) ? VSP : ~VSP;
        e_bl   = (x < HA) && (y < VA);
        e_ls   = pe && (x == 0);
        e_fs   = pe && (p == 0);
        chk("cycle",
            {31'd0, pix_en, pixel_clk, hs, vs, blank, sync, DrawX, DrawY,
             line_start, frame_start, swap_ack, waitFrame, buffer_sel, frame_count},
            {31'd0, pe, e_pclk, e_hs, e_vs, e_bl, 1'b0, 3'(x), 3'(y),
             e_ls, e_fs, m_ack, m_pend, m_buf, 16'(fc)});
    endtask

    typedef struct {
        int          t;
        logic [2:0]  x, y;
        logic        hs, vs, bl, pe, ls, fs;
        logic [15:0] fc;
    } vec_t;

    vec_t vecs[17];
    int   acks;
    int   hold;

    initial begin
        //           t    x  y  hs vs bl pe ls fs fc
        vecs[0]  = '{0,   0, 0, 1, 1, 1, 0, 0, 0, 0};
        vecs[1]  = '{1,   0, 0, 1, 1, 1, 0, 0, 0, 0};
        vecs[2]  = '{2,   1, 0, 1, 1, 1, 1, 0, 0, 0};
        vecs[3]  = '{8,   4, 0, 1, 1, 0, 1, 0, 0, 0};
        vecs[4]  = '{10,  5, 0, 0, 1, 0, 1, 0, 0, 0};
        vecs[5]  = '{12,  6, 0, 0, 1, 0, 1, 0, 0, 0};
        vecs[6]  = '{13,  6, 0, 0, 1, 0, 0, 0, 0, 0};
        vecs[7]  = '{14,  7, 0, 1, 1, 0, 1, 0, 0, 0};
        vecs[8]  = '{16,  0, 1, 1, 1, 1, 1, 1, 0, 0};
        vecs[9]  = '{17,  0, 1, 1, 1, 1, 0, 0, 0, 0};
        vecs[10] = '{48,  0, 3, 1, 1, 0, 1, 1, 0, 0};
        vecs[11] = '{64,  0, 4, 1, 0, 0, 1, 1, 0, 0};
        vecs[12] = '{78,  7, 4, 1, 0, 0, 1, 0, 0, 0};
        vecs[13] = '{80,  0, 5, 1, 1, 0, 1, 1, 0, 0};
        vecs[14] = '{96,  0, 0, 1, 1, 1, 1, 1, 1, 1};
        vecs[15] = '{97,  0, 0, 1, 1, 1, 0, 0, 0, 1};
        vecs[16] = '{288, 0, 0, 1, 1, 1, 1, 1, 1, 3};

        step(1'b0, 1'b1);
        for (int i = 0; i < 17; i++) begin
            while (t < vecs[i].t) step(1'b0, 1'b0);
            chk($sformatf("vec%0d", i),
                {36'd0, DrawX, DrawY, hs, vs, blank, pix_en, line_start, frame_start, frame_count},
                {36'd0, vecs[i].x, vecs[i].y, vecs[i].hs, vecs[i].vs, vecs[i].bl,
                 vecs[i].pe, vecs[i].ls, vecs[i].fs, vecs[i].fc});
        end

        // One-cycle request during DrawY=1 waits for the next boundary
        while (t < 306) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("pend_wait", {63'd0, waitFrame}, 64'd1);
        for (int k = 0; k < 200 && !swap_ack; k++) step(1'b0, 1'b0);
        chk("ack_a", {63'd0, swap_ack}, 64'd1);
        chk("ack_a_time", 64'(t), 64'd384);
        chk("ack_a_buf", {63'd0, buffer_sel}, 64'd1);
        step(1'b0, 1'b0);
        chk("ack_a_after", {62'd0, swap_ack, waitFrame}, 64'd0);

        // Request on the boundary cycle itself, then held through ack and one more Clk
        while (t < 479) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("ack_b", {61'd0, swap_ack, waitFrame, buffer_sel}, 64'b100);
        step(1'b1, 1'b0);
        chk("ack_b_ignored", {63'd0, waitFrame}, 64'd0);
        step(1'b1, 1'b0);
        chk("ack_b_rearm", {63'd0, waitFrame}, 64'd1);
        for (int k = 0; k < 200 && !swap_ack; k++) step(1'b0, 1'b0);
        chk("ack_c_time", 64'(t), 64'd576);
        chk("ack_c_buf", {62'd0, swap_ack, buffer_sel}, 64'b11);

        // Reset mid-frame with a pending swap
        while (t < 610) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("rst_pend", {63'd0, waitFrame}, 64'd1);
        step(1'b0, 1'b1);
        chk("rst_vals",
            {35'd0, DrawX, DrawY, hs, vs, blank, pix_en, pixel_clk, line_start, frame_start,
             swap_ack, waitFrame, buffer_sel, frame_count},
            {35'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b0, 1'b0, 1'b0, 16'd0});
        acks = 0;
        repeat (200) begin
            step(1'b0, 1'b0);
            if (swap_ack) acks++;
        end
        chk("rst_no_ack", 64'(acks), 64'd0);

        // Random requests of varying length with occasional resets
        hold = 0;
        repeat (3000) begin
            logic r;
            if (hold > 0) begin
                r = 1'b1;
                hold--;
            end else begin
                r = 1'b0;
                if ($urandom_range(0, 39) == 0) hold = $urandom_range(1, 4);
            end
            step(r, ($urandom_range(0, 599) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
